// File: rtl/accumulator_driver.sv
// Drives an external accumulator with a programmed train of enable pulses,
// then reads its result back and compares it against an internally modelled sum.
module accumulator_driver #(
   parameter int unsigned Word_Length  = 8,
   parameter int unsigned Count_Length = 8
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic [Word_Length-1:0]  Value,
   input  logic [Count_Length-1:0] Count,
   input  logic [Count_Length-1:0] Gap,
   input  logic [Word_Length-1:0]  Acc_Data,
   output logic                    enable,
   output logic                    Read,
   output logic [Word_Length-1:0]  Data_Output,
   output logic                    busy,
   output logic                    done,
   output logic                    match,
   output logic [Word_Length-1:0]  Expected
);

   typedef enum logic [2:0] {StIdle, StPulse, StGap, StRead, StCheck} state_e;

   state_e                  r_state;
   state_e                  w_state_d;
   logic [Word_Length-1:0]  r_data;
   logic [Word_Length-1:0]  r_expected;
   logic [Count_Length-1:0] r_gap;
   logic [Count_Length-1:0] r_remaining;
   logic [Count_Length-1:0] r_gap_cnt;
   logic                    r_match;
   logic                    r_enable;
   logic                    r_read;
   logic                    r_busy;
   logic                    r_done;
   logic                    w_enable_d;
   logic                    w_read_d;
   logic                    w_busy_d;
   logic                    w_done_d;
   logic                    w_last;

   assign w_last = (r_remaining == Count_Length'(1));

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_d;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_d = r_state;
      case (r_state)
         StIdle: begin
            if (start) begin
               w_state_d = (Count != '0) ? StPulse : StRead;
            end
         end
         StPulse: begin
            if (w_last) begin
               w_state_d = StRead;
            end else if (r_gap == '0) begin
               w_state_d = StPulse;
            end else begin
               w_state_d = StGap;
            end
         end
         StGap: begin
            if (r_gap_cnt == '0) begin
               w_state_d = StPulse;
            end
         end
         StRead:  w_state_d = StCheck;
         StCheck: w_state_d = StIdle;
         default: w_state_d = StIdle;
      endcase
   end

   // Output logic: decoded from the next state so every output leaves a flop
   always_comb begin
      w_enable_d = (w_state_d == StPulse);
      w_read_d   = (w_state_d == StRead) || (w_state_d == StCheck);
      w_busy_d   = (w_state_d != StIdle);
      w_done_d   = (r_state == StCheck);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_data      <= '0;
         r_expected  <= '0;
         r_gap       <= '0;
         r_remaining <= '0;
         r_gap_cnt   <= '0;
         r_match     <= 1'b0;
         r_enable    <= 1'b0;
         r_read      <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_enable <= w_enable_d;
         r_read   <= w_read_d;
         r_busy   <= w_busy_d;
         r_done   <= w_done_d;
         case (r_state)
            StIdle: begin
               if (start) begin
                  r_data      <= Value;
                  r_gap       <= Gap;
                  r_remaining <= Count;
                  r_expected  <= '0;
                  r_match     <= 1'b0;
               end
            end
            StPulse: begin
               r_expected  <= r_expected + r_data;
               r_remaining <= r_remaining - Count_Length'(1);
               // GAP exits when the counter reads zero, so preload Gap-1
               r_gap_cnt   <= r_gap - Count_Length'(1);
            end
            StGap: begin
               if (r_gap_cnt != '0) begin
                  r_gap_cnt <= r_gap_cnt - Count_Length'(1);
               end
            end
            StCheck: begin
               r_match <= (Acc_Data == r_expected);
            end
            default: begin
            end
         endcase
      end
   end

   assign enable      = r_enable;
   assign Read        = r_read;
   assign Data_Output = r_data;
   assign busy        = r_busy;
   assign done        = r_done;
   assign match       = r_match;
   assign Expected    = r_expected;

endmodule

// File: tb/tb_accumulator_driver.sv
// Directed bench for accumulator_driver: pulse timing, readback check, wrap,
// mid-sequence reset and ignored starts, against hand-computed values.
module tb_accumulator_driver;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic [7:0] Value;
   logic [7:0] Count;
   logic [7:0] Gap;
   logic [7:0] Acc_Data;
   logic       enable;
   logic       Read;
   logic [7:0] Data_Output;
   logic       busy;
   logic       done;
   logic       match;
   logic [7:0] Expected;

   int n_total = 0;
   int n_pass  = 0;

   accumulator_driver #(
      .Word_Length  (8),
      .Count_Length (8)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .Value       (Value),
      .Count       (Count),
      .Gap         (Gap),
      .Acc_Data    (Acc_Data),
      .enable      (enable),
      .Read        (Read),
      .Data_Output (Data_Output),
      .busy        (busy),
      .done        (done),
      .match       (match),
      .Expected    (Expected)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Starts a sequence and records the cycle indices (1 = cycle after the start edge)
   // of enable/Read activity until done. inj > 0 pulses a busy-time start with Value=9.
   task automatic run(input string tag, input logic [7:0] v, input logic [7:0] c,
                      input logic [7:0] g, input logic [7:0] a, input int inj,
                      output int n_en, output int f_en, output int l_en,
                      output int n_rd, output int f_rd, output int d_at);
      n_en = 0; f_en = 0; l_en = 0; n_rd = 0; f_rd = 0; d_at = 0;
      Value = v; Count = c; Gap = g; Acc_Data = a; start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 1; k <= 200; k++) begin
         if (k == 1) begin
            check({tag, "_busy_c1"}, 32'(busy), 32'd1);
            check({tag, "_match_clr"}, 32'(match), 32'd0);
         end
         if (enable) begin
            n_en++;
            if (f_en == 0) f_en = k;
            l_en = k;
         end
         if (Read) begin
            n_rd++;
            if (f_rd == 0) f_rd = k;
         end
         if (done) begin
            d_at = k;
            break;
         end
         if (inj > 0 && k == inj) begin
            start = 1'b1; Value = 8'd9; Count = 8'd1; Gap = 8'd0;
         end else if (inj > 0 && k == inj + 1) begin
            start = 1'b0;
         end
         tick();
      end
      check({tag, "_done_seen"}, 32'(d_at != 0), 32'd1);
   endtask

   int n_en, f_en, l_en, n_rd, f_rd, d_at;

   initial begin
      reset = 1'b1; start = 1'b1; Value = 8'd3; Count = 8'd6; Gap = 8'd2; Acc_Data = 8'd0;
      tick();
      tick();
      // Reset wins over start held high
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_enable", 32'(enable), 32'd0);
      check("rst_read", 32'(Read), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_match", 32'(match), 32'd0);
      check("rst_dout", 32'(Data_Output), 32'd0);
      check("rst_exp", 32'(Expected), 32'd0);
      reset = 1'b0;

      // 3 x 6, gap 2: pulses at 1,4,...,16, Read 17-18, done 19
      run("basic", 8'd3, 8'd6, 8'd2, 8'd18, 0, n_en, f_en, l_en, n_rd, f_rd, d_at);
      check("basic_n_en", n_en, 6);
      check("basic_first_en", f_en, 1);
      check("basic_last_en", l_en, 16);
      check("basic_n_rd", n_rd, 2);
      check("basic_first_rd", f_rd, 17);
      check("basic_done_at", d_at, 19);
      check("basic_exp", 32'(Expected), 32'd18);
      check("basic_match", 32'(match), 32'd1);
      check("basic_dout", 32'(Data_Output), 32'd3);
      check("basic_busy_done", 32'(busy), 32'd0);

      // Count=0 accepted in the done cycle: Read in cycles 1-2, done at 3
      run("zero", 8'd5, 8'd0, 8'd2, 8'd0, 0, n_en, f_en, l_en, n_rd, f_rd, d_at);
      check("zero_n_en", n_en, 0);
      check("zero_first_rd", f_rd, 1);
      check("zero_n_rd", n_rd, 2);
      check("zero_done_at", d_at, 3);
      check("zero_exp", 32'(Expected), 32'd0);
      check("zero_match", 32'(match), 32'd1);

      // 200*2 = 400 wraps to 144; back-to-back pulses
      run("wrap", 8'd200, 8'd2, 8'd0, 8'd144, 0, n_en, f_en, l_en, n_rd, f_rd, d_at);
      check("wrap_n_en", n_en, 2);
      check("wrap_last_en", l_en, 2);
      check("wrap_first_rd", f_rd, 3);
      check("wrap_done_at", d_at, 5);
      check("wrap_exp", 32'(Expected), 32'd144);
      check("wrap_match", 32'(match), 32'd1);

      // Wrong readback value
      run("miss", 8'd3, 8'd6, 8'd2, 8'd17, 0, n_en, f_en, l_en, n_rd, f_rd, d_at);
      check("miss_done_at", d_at, 19);
      check("miss_exp", 32'(Expected), 32'd18);
      check("miss_match", 32'(match), 32'd0);
      tick();
      check("miss_done_1cyc", 32'(done), 32'd0);
      check("miss_match_hold", 32'(match), 32'd0);

      // Start with Value=9 while busy is ignored
      run("ign", 8'd3, 8'd6, 8'd2, 8'd18, 5, n_en, f_en, l_en, n_rd, f_rd, d_at);
      check("ign_n_en", n_en, 6);
      check("ign_done_at", d_at, 19);
      check("ign_dout", 32'(Data_Output), 32'd3);
      check("ign_exp", 32'(Expected), 32'd18);
      check("ign_match", 32'(match), 32'd1);
      tick();

      // Gap=3: pulse at 1, GAP cycles 2,3,4; reset sampled at end of cycle 4
      Value = 8'd3; Count = 8'd6; Gap = 8'd3; Acc_Data = 8'd18; start = 1'b1;
      tick();
      start = 1'b0;
      check("mid_en_c1", 32'(enable), 32'd1);
      tick();
      tick();
      tick();
      check("mid_gap_c4", 32'(enable), 32'd0);
      check("mid_busy_c4", 32'(busy), 32'd1);
      reset = 1'b1;
      tick();
      check("mid_enable", 32'(enable), 32'd0);
      check("mid_read", 32'(Read), 32'd0);
      check("mid_done", 32'(done), 32'd0);
      check("mid_match", 32'(match), 32'd0);
      check("mid_busy", 32'(busy), 32'd0);
      check("mid_dout", 32'(Data_Output), 32'd0);
      check("mid_exp", 32'(Expected), 32'd0);
      reset = 1'b0;

      // 7 x 3, gap 1: pulses 1,3,5, Read 6-7, done 8
      run("post", 8'd7, 8'd3, 8'd1, 8'd21, 0, n_en, f_en, l_en, n_rd, f_rd, d_at);
      check("post_n_en", n_en, 3);
      check("post_last_en", l_en, 5);
      check("post_first_rd", f_rd, 6);
      check("post_done_at", d_at, 8);
      check("post_exp", 32'(Expected), 32'd21);
      check("post_match", 32'(match), 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/accumulator_driver.md
ACCUMULATOR_DRIVER -- requirements
Module: accumulator_driver

Interface
REQ-001 Parameter Word_Length, default 8: width of the data path and of the sum check.
REQ-002 Parameter Count_Length, default 8: width of the pulse-count and gap fields.
REQ-003 clk  input  1  single clock for all state; rising-edge.
REQ-004 reset  input  1  synchronous, active-high reset; sampled on the rising edge of clk.
REQ-005 start  input  1  request to begin a sequence; sampled only in IDLE.
REQ-006 Value  input  Word_Length  data word presented to the accumulator on every pulse.
REQ-007 Count  input  Count_Length  number of enable pulses to issue.
REQ-008 Gap  input  Count_Length  idle cycles between consecutive enable pulses.
REQ-009 Acc_Data  input  Word_Length  accumulator's output word, returned for checking.
REQ-010 enable  output  1  one-cycle strobe to the accumulator's enable input.
REQ-011 Read  output  1  read request to the accumulator.
REQ-012 Data_Output  output  Word_Length  drives the accumulator's data input.
REQ-013 busy  output  1  high whenever the state is not IDLE.
REQ-014 done  output  1  one-cycle pulse at sequence end.
REQ-015 match  output  1  result of the last check; Acc_Data equals Expected.
REQ-016 Expected  output  Word_Length  modelled sum: Value*Count mod 2^Word_Length.

Function
REQ-017 FSM states: IDLE, PULSE, GAP, READ, CHECK. All outputs are registered.
REQ-018 IDLE, start=1 at edge N: latch Value, Count and Gap; clear Expected and match; remaining=Count. Go to PULSE if Count!=0, otherwise go to READ.
REQ-019 PULSE lasts exactly one cycle with enable=1. On exit: Expected += Value (mod 2^Word_Length), remaining -= 1.
REQ-020 PULSE exit rules:
  - remaining reaches 0: go to READ.
  - else Gap=0: go to PULSE (back-to-back pulses).
  - else: go to GAP.
REQ-021 GAP holds enable=0 for exactly the latched Gap cycles, then goes to PULSE. Pulse period = Gap+1 cycles.
REQ-022 First enable is high in the cycle after edge N, i.e. latency of 1 cycle from start.
REQ-023 READ and CHECK each last one cycle with Read=1 (two cycles total).
REQ-024 Acc_Data is sampled on the edge ending CHECK:
  - match <= (Acc_Data == Expected).
  - done=1 for the following single cycle.
  - state goes to IDLE.
REQ-025 Data_Output holds the latched Value from the cycle after start until the next accepted start.
REQ-026 Expected and match hold their values in IDLE until the next accepted start.
REQ-027 start while busy=1 is ignored; latched Value, Count and Gap are unaffected.
REQ-028 start asserted in the same cycle done=1 (state IDLE) is accepted.
REQ-029 Value, Count and Gap changes after latching have no effect on the running sequence.
REQ-030 Arithmetic is unsigned and wraps modulo 2^Word_Length; no overflow flag.

Reset
REQ-031 reset=1 at any edge, including mid-sequence, forces:
  - state IDLE, remaining 0;
  - enable, Read, done, match and busy = 0;
  - Data_Output and Expected = 0.
REQ-032 reset has priority over start in the same cycle. The first start is accepted on the first edge with reset=0.

Verification
REQ-033 Value=3, Count=6, Gap=2, Acc_Data model returns 18 -> six enable pulses 3 cycles apart, first one 1 cycle after start; Read high 2 cycles; done pulse; match=1; Expected=18.
REQ-034 Count=0, Value=5, Acc_Data=0 -> no enable pulse; Read high in cycles 1-2 after start; done; match=1; Expected=0.
REQ-035 Value=200, Count=2, Gap=0 -> enable high 2 consecutive cycles; Expected=144 (wrap); Acc_Data=144 gives match=1.
REQ-036 Value=3, Count=6, Acc_Data=17 -> done pulse, match=0, Expected=18.
REQ-037 reset=1 during the third GAP cycle -> next cycle all outputs 0, busy=0; a new start then runs a full sequence correctly.
REQ-038 start pulsed again while busy with Value=9 -> ignored; Data_Output remains 3; Expected still ends at 18.
